mem_arbiter: RTL
================

# mem_arbiter

Two-port request arbiter that sits directly upstream of `memctrl` and drives its controller read/write interface. It accepts read or write requests from two masters (port 0 and port 1, e.g. instruction fetch and load/store), serialises them with round-robin priority, and issues exactly one single-cycle read or write strobe per transaction. It waits for `memctrl` to report completion, then returns the read data or write acknowledgement to the owning master. A watchdog terminates any transaction that `memctrl` never completes.

## Interface
- RAM_WIDTH, 8, data width in bits; must match `memctrl`.
- RAM_DEPTH, 8, memory depth in words.
- ADDR_W, 3, address width in bits; equals $clog2(RAM_DEPTH).
- TIMEOUT, 16, number of WAIT cycles without a completion strobe before the transaction is aborted (2..255).

- clk_i  in  1  clock; all logic on the rising edge.
- rstn_i  in  1  reset; asynchronous, active-low.
- m0_req_i / m1_req_i  in  1  request; level, held until the matching ack.
- m0_we_i / m1_we_i  in  1  1 = write, 0 = read.
- m0_addr_i / m1_addr_i  in  ADDR_W  word address.
- m0_wdata_i / m1_wdata_i  in  RAM_WIDTH  write data.
- m0_ack_o / m1_ack_o  out  1  one-cycle completion pulse.
- m0_rdata_o / m1_rdata_o  out  RAM_WIDTH  read data; valid while ack is high and the transaction was a read.
- m0_err_o / m1_err_o  out  1  high together with ack when the transaction timed out.
- cntlr_rd_o  out  1  read strobe to `memctrl`.
- cntlr_raddr_o  out  ADDR_W  read address.
- cntlr_wr_o  out  1  write strobe to `memctrl`.
- cntlr_waddr_o  out  ADDR_W  write address.
- cntlr_wr_data_o  out  RAM_WIDTH  write data.
- cntlr_rd_data_i  in  RAM_WIDTH  read data from `memctrl`.
- cntlr_rd_valid_i  in  1  read complete.
- cntlr_wr_done_i  in  1  write complete.
- busy_o  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any request is high, select the owner by round-robin.
  - Latch the owner's we, addr and wdata into internal registers; the master's fields are not used again.
  - Go to ISSUE.
- Round-robin:
  - The priority pointer resets to port 0.
  - With one request pending, that port wins.
  - With both pending, the pointer port wins.
  - After every DONE, the pointer moves to the port not just served, including after a timeout.
- ISSUE:
  - Drive `cntlr_rd_o` or `cntlr_wr_o` high for exactly this one cycle, according to the latched we.
  - Addresses and write data come from the latched registers and are held stable from ISSUE through DONE.
  - `cntlr_rd_o` and `cntlr_wr_o` are never high in the same cycle.
  - Clear the timeout counter and go to WAIT.
- WAIT:
  - A latched read completes on `cntlr_rd_valid_i`; capture `cntlr_rd_data_i` into the owner's rdata register.
  - A latched write completes on `cntlr_wr_done_i`.
  - The strobe of the other type is ignored.
  - On completion, go to DONE.
  - Otherwise increment the counter; when it reaches TIMEOUT, go to DONE with the err flag set.
- DONE:
  - Owner's ack is high for exactly this cycle; err is high in the same cycle if the transaction timed out.
  - rdata holds its captured value until the next read completion on that port.
  - Requests are not sampled in DONE, so a master's stale req cannot be accepted twice. The master drops or updates req on seeing ack.
  - Go to IDLE.
- Completion strobes arriving in IDLE, ISSUE or DONE are ignored.
- Reset, asynchronous and possibly mid-transaction:
  - State returns to IDLE and the pointer to 0.
  - All outputs go to 0: strobes, acks, errs, rdata, addresses, wr_data, busy_o.
  - An interrupted transaction is dropped with no ack.

## Timing
- Request sampled high at edge E0 in IDLE gives ISSUE in the following cycle (strobe high E0..E1).
- Earliest completion strobe sampled at edge Ek gives ack high Ek..Ek+1.
- Minimum request-to-ack latency is 3 cycles plus `memctrl` latency.
- Back-to-back requests from the same port: next ISSUE no earlier than 2 cycles after ack (DONE → IDLE → ISSUE).
- Timeout ack is asserted TIMEOUT+1 cycles after the ISSUE cycle ends.
- All outputs are registered.

## Test plan
- Port 0 writes 0xA5 to addr 3, then reads addr 3 → exactly one `cntlr_wr_o` pulse, then one `cntlr_rd_o` pulse; m0_ack pulses twice; m0_rdata=0xA5; err=0.
- Both ports request reads of addr 1 and addr 2 in the same cycle after reset → port 0 is served first, then port 1; strobes never overlap; each ack is high for one cycle.
- Both ports hold req continuously for 8 transactions → grants alternate 0,1,0,1…; no duplicate issue for a held req.
- `memctrl` replaced by a stub that never completes; port 1 reads → m1_ack and m1_err are high together 17 cycles after the ISSUE cycle; FSM returns to IDLE; pointer moves to port 0.
- Stray `cntlr_rd_valid_i` during IDLE and during a pending write → ignored; no ack until `cntlr_wr_done_i`.
- rstn_i asserted in WAIT → all outputs 0 immediately; after release, a new port 1 request completes normally with no spurious ack from the aborted transaction.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-master request arbiter in front of the memctrl read/write interface.
// Requests from port 0 and port 1 are serialised with round-robin priority.
// Each transaction produces exactly one single-cycle read or write strobe.
// The owning master gets a one-cycle ack once memctrl reports completion.
// A watchdog ends any transaction that memctrl never completes; that ack carries err.
//
// Ports:
//   clk_i, rstn_i               clock (rising edge), asynchronous active-low reset
//   m{0,1}_req_i                level request, held until the matching ack
//   m{0,1}_we_i                 1 = write, 0 = read
//   m{0,1}_addr_i/_wdata_i      word address / write data
//   m{0,1}_ack_o                one-cycle completion pulse
//   m{0,1}_rdata_o              read data, valid with ack on a read
//   m{0,1}_err_o                high with ack when the transaction timed out
//   cntlr_rd_o/_raddr_o         read strobe and address to memctrl
//   cntlr_wr_o/_waddr_o         write strobe and address to memctrl
//   cntlr_wr_data_o             write data to memctrl
//   cntlr_rd_data_i/_valid_i    read data and read-complete from memctrl
//   cntlr_wr_done_i             write-complete from memctrl
//   busy_o                      high whenever the FSM is not idle
module mem_arbiter #(
    parameter int RAM_WIDTH = 8,
    parameter int RAM_DEPTH = 8,
    parameter int ADDR_W    = $clog2(RAM_DEPTH),
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 m0_req_i,
    input  logic                 m0_we_i,
    input  logic [ADDR_W-1:0]    m0_addr_i,
    input  logic [RAM_WIDTH-1:0] m0_wdata_i,
    output logic                 m0_ack_o,
    output logic [RAM_WIDTH-1:0] m0_rdata_o,
    output logic                 m0_err_o,
    input  logic                 m1_req_i,
    input  logic                 m1_we_i,
    input  logic [ADDR_W-1:0]    m1_addr_i,
    input  logic [RAM_WIDTH-1:0] m1_wdata_i,
    output logic                 m1_ack_o,
    output logic [RAM_WIDTH-1:0] m1_rdata_o,
    output logic                 m1_err_o,
    output logic                 cntlr_rd_o,
    output logic [ADDR_W-1:0]    cntlr_raddr_o,
    output logic                 cntlr_wr_o,
    output logic [ADDR_W-1:0]    cntlr_waddr_o,
    output logic [RAM_WIDTH-1:0] cntlr_wr_data_o,
    input  logic [RAM_WIDTH-1:0] cntlr_rd_data_i,
    input  logic                 cntlr_rd_valid_i,
    input  logic                 cntlr_wr_done_i,
    output logic                 busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t               state_r;
    logic                 ptr_r;      // port that wins when both request
    logic                 owner_r;    // port that owns the current transaction
    logic                 we_r;       // latched transfer direction
    logic [7:0]           cnt_r;      // WAIT-cycle watchdog counter

    logic                 grant_s;
    logic                 sel_we_s;
    logic [ADDR_W-1:0]    sel_addr_s;
    logic [RAM_WIDTH-1:0] sel_wdata_s;
    logic                 done_s;

    // Round-robin owner selection and mux of the winner's request fields.
    always_comb begin
        grant_s = 1'b0;
        if (m0_req_i && m1_req_i) begin
            grant_s = ptr_r;
        end else if (m1_req_i) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        if (grant_s) begin
            sel_we_s    = m1_we_i;
            sel_addr_s  = m1_addr_i;
            sel_wdata_s = m1_wdata_i;
        end else begin
            sel_we_s    = m0_we_i;
            sel_addr_s  = m0_addr_i;
            sel_wdata_s = m0_wdata_i;
        end
    end

    // Only the completion strobe matching the latched direction counts.
    always_comb begin
        done_s = 1'b0;
        if (we_r) begin
            done_s = cntlr_wr_done_i;
        end else begin
            done_s = cntlr_rd_valid_i;
        end
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r         <= ST_IDLE;
            ptr_r           <= 1'b0;
            owner_r         <= 1'b0;
            we_r            <= 1'b0;
            cnt_r           <= 8'd0;
            m0_ack_o        <= 1'b0;
            m1_ack_o        <= 1'b0;
            m0_err_o        <= 1'b0;
            m1_err_o        <= 1'b0;
            m0_rdata_o      <= '0;
            m1_rdata_o      <= '0;
            cntlr_rd_o      <= 1'b0;
            cntlr_wr_o      <= 1'b0;
            cntlr_raddr_o   <= '0;
            cntlr_waddr_o   <= '0;
            cntlr_wr_data_o <= '0;
            busy_o          <= 1'b0;
        end else begin
            // Strobes, acks and errs are single-cycle pulses.
            cntlr_rd_o <= 1'b0;
            cntlr_wr_o <= 1'b0;
            m0_ack_o   <= 1'b0;
            m1_ack_o   <= 1'b0;
            m0_err_o   <= 1'b0;
            m1_err_o   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (m0_req_i || m1_req_i) begin
                        // The address/data output registers double as the
                        // latched request; they stay stable until DONE.
                        owner_r         <= grant_s;
                        we_r            <= sel_we_s;
                        cntlr_raddr_o   <= sel_addr_s;
                        cntlr_waddr_o   <= sel_addr_s;
                        cntlr_wr_data_o <= sel_wdata_s;
                        cntlr_rd_o      <= ~sel_we_s;
                        cntlr_wr_o      <= sel_we_s;
                        busy_o          <= 1'b1;
                        state_r         <= ST_ISSUE;
                    end else begin
                        busy_o <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    cnt_r   <= 8'd0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_s) begin
                        if (!we_r) begin
                            if (owner_r) begin
                                m1_rdata_o <= cntlr_rd_data_i;
                            end else begin
                                m0_rdata_o <= cntlr_rd_data_i;
                            end
                        end
                        m0_ack_o <= ~owner_r;
                        m1_ack_o <= owner_r;
                        state_r  <= ST_DONE;
                    end else if (cnt_r == TIMEOUT_C) begin
                        m0_ack_o <= ~owner_r;
                        m1_ack_o <= owner_r;
                        m0_err_o <= ~owner_r;
                        m1_err_o <= owner_r;
                        state_r  <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    // Requests are deliberately not sampled here.
                    ptr_r   <= ~owner_r;
                    busy_o  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_o  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
